// File: rtl/rs_stream_encoder.sv
// Streaming systematic Reed-Solomon encoder over GF(2^SYM_W).
// Message symbols pass straight through a one-deep output register. Once a frame
// ends, NPAR parity symbols follow, highest degree first, taken from an LFSR that
// divides by the generator polynomial.
module rs_stream_encoder #(
  parameter int unsigned SYM_W     = 4,
  parameter int unsigned NPAR      = 4,
  parameter int unsigned K         = 11,
  parameter int unsigned PRIM_POLY = 'h13,
  parameter int unsigned FCR       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [SYM_W-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [SYM_W-1:0] m_data,
  output logic             m_parity,
  output logic             m_last,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(K + 1);
  localparam int unsigned ParW = $clog2(NPAR + 1);
  // Reduction term: PRIM_POLY without its x^SYM_W bit
  localparam logic [SYM_W-1:0] PolyLo = SYM_W'(PRIM_POLY);
  localparam logic [SYM_W-1:0] One    = SYM_W'(1);
  localparam logic [SYM_W-1:0] Two    = SYM_W'(2);

  // Shift-and-reduce multiply in GF(2^SYM_W)
  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                              input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] acc;
    logic [SYM_W-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < int'(SYM_W); i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[SYM_W-1] ? ((sh << 1) ^ PolyLo) : (sh << 1);
    end
    return acc;
  endfunction

  // Low NPAR coefficients of g(x) = prod_{i=0}^{NPAR-1} (x + alpha^(FCR+i)).
  // The leading coefficient is always 1, so it is not returned.
  function automatic logic [NPAR*SYM_W-1:0] gen_poly();
    logic [(NPAR+1)*SYM_W-1:0] g;
    logic [SYM_W-1:0]          root;
    g = '0;
    g[0 +: SYM_W] = One;
    root = One;
    for (int i = 0; i < int'(FCR); i++) root = gf_mul(root, Two);
    for (int i = 0; i < int'(NPAR); i++) begin
      // Multiply by (x + root); going downwards uses each old g[j-1] before it is overwritten
      for (int j = int'(NPAR); j > 0; j--) begin
        g[j*SYM_W +: SYM_W] = g[(j-1)*SYM_W +: SYM_W] ^ gf_mul(g[j*SYM_W +: SYM_W], root);
      end
      g[0 +: SYM_W] = gf_mul(g[0 +: SYM_W], root);
      root = gf_mul(root, Two);
    end
    return g[NPAR*SYM_W-1:0];
  endfunction

  localparam logic [NPAR*SYM_W-1:0] Gen = gen_poly();

  typedef enum logic {StMsg, StPar} state_e;

  state_e           state_q;
  logic [CntW-1:0]  sym_cnt_q;
  logic [ParW-1:0]  par_cnt_q;
  logic [SYM_W-1:0] r_q     [NPAR];
  logic [SYM_W-1:0] r_enc   [NPAR];
  logic [SYM_W-1:0] r_shift [NPAR];
  logic [SYM_W-1:0] fb;
  logic             adv;
  logic             frame_end;

  // Handshake, divider feedback and next LFSR contents for both modes
  always_comb begin
    adv       = !m_valid || m_ready;
    s_ready   = (state_q == StMsg) && adv;
    busy      = (state_q != StMsg) || (sym_cnt_q != '0);
    frame_end = s_last || (sym_cnt_q == CntW'(K - 1));
    fb        = s_data ^ r_q[NPAR-1];
    for (int i = 0; i < int'(NPAR); i++) begin
      r_shift[i] = (i == 0) ? '0 : r_q[(i == 0) ? 0 : i-1];
      r_enc[i]   = r_shift[i] ^ gf_mul(Gen[i*SYM_W +: SYM_W], fb);
    end
  end

  // Control FSM, LFSR and registered output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StMsg;
      sym_cnt_q <= '0;
      par_cnt_q <= '0;
      for (int i = 0; i < int'(NPAR); i++) r_q[i] <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_parity  <= 1'b0;
      m_last    <= 1'b0;
    end else begin
      case (state_q)
        StMsg: begin
          if (s_valid && s_ready) begin
            m_data   <= s_data;
            m_parity <= 1'b0;
            m_last   <= 1'b0;
            m_valid  <= 1'b1;
            for (int i = 0; i < int'(NPAR); i++) r_q[i] <= r_enc[i];
            if (frame_end) begin
              state_q   <= StPar;
              sym_cnt_q <= '0;
              par_cnt_q <= '0;
            end else begin
              sym_cnt_q <= sym_cnt_q + CntW'(1);
            end
          end else if (m_ready) begin
            m_valid <= 1'b0;
          end
        end
        StPar: begin
          if (adv) begin
            m_data   <= r_q[NPAR-1];
            m_parity <= 1'b1;
            m_valid  <= 1'b1;
            for (int i = 0; i < int'(NPAR); i++) r_q[i] <= r_shift[i];
            // Shifting NPAR times empties the LFSR, so the next frame starts clean
            if (par_cnt_q == ParW'(NPAR - 1)) begin
              m_last    <= 1'b1;
              state_q   <= StMsg;
              par_cnt_q <= '0;
            end else begin
              m_last    <= 1'b0;
              par_cnt_q <= par_cnt_q + ParW'(1);
            end
          end
        end
        default: state_q <= StMsg;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_stream_encoder.sv
// Directed bench for rs_stream_encoder: default RS(15,11) instance plus an
// RS(255,239)-style instance checked with a syndrome reference model.
module tb_rs_stream_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, s_ready, s_last, m_valid, m_ready, m_parity, m_last, busy;
  logic [3:0] s_data, m_data;

  logic       w_s_valid, w_s_ready, w_s_last, w_m_valid, w_m_ready, w_m_parity, w_m_last, w_busy;
  logic [7:0] w_s_data, w_m_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [5:0] beats[$];
  int         beat_cyc[$];
  logic [5:0] exp_q[$];
  logic [7:0] wbeats[$];

  always #5 clk = ~clk;

  rs_stream_encoder dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_parity(m_parity), .m_last(m_last), .busy(busy)
  );

  rs_stream_encoder #(
    .SYM_W(8), .NPAR(16), .K(239), .PRIM_POLY('h11D), .FCR(0)
  ) dut_w (
    .clk(clk), .rst(rst), .s_valid(w_s_valid), .s_ready(w_s_ready), .s_data(w_s_data),
    .s_last(w_s_last), .m_valid(w_m_valid), .m_ready(w_m_ready), .m_data(w_m_data),
    .m_parity(w_m_parity), .m_last(w_m_last), .busy(w_busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted output beat; inputs change only just after posedge
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      beats.push_back({m_last, m_parity, m_data});
      beat_cyc.push_back(cyc);
    end
    if (!rst && w_m_valid && w_m_ready) wbeats.push_back(w_m_data);
  end

  function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[7] ? ((sh << 1) ^ 8'h1D) : (sh << 1);
    end
    return acc;
  endfunction

  // Hand-computed parity (highest degree first) for 0..0,v messages
  function automatic logic [15:0] par_of(input logic [3:0] v);
    case (v)
      4'h1:    return 16'hDC87;
      4'h2:    return 16'h9B3E;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic expect_frame(input int len, input logic [3:0] last_val);
    logic [15:0] p;
    for (int i = 0; i < len - 1; i++) exp_q.push_back({2'b00, 4'h0});
    exp_q.push_back({2'b00, last_val});
    p = par_of(last_val);
    exp_q.push_back({2'b01, p[15:12]});
    exp_q.push_back({2'b01, p[11:8]});
    exp_q.push_back({2'b01, p[7:4]});
    exp_q.push_back({2'b11, p[3:0]});
  endtask

  task automatic clear_all();
    beats.delete();
    beat_cyc.delete();
    exp_q.delete();
  endtask

  task automatic send_sym(input logic [3:0] d, input logic last);
    int   budget;
    logic hs;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    budget  = 0;
    hs      = 1'b0;
    while (!hs && budget < 200) begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!hs) begin
      checks++;
      failures++;
      $display("FAIL send_sym: s_ready never seen, got 0 required 1");
    end
  endtask

  task automatic send_frame(input int len, input logic [3:0] last_val, input logic use_last);
    for (int i = 0; i < len; i++) begin
      send_sym((i == len - 1) ? last_val : 4'h0, use_last && (i == len - 1));
    end
  endtask

  task automatic wait_beats(input int n, input string name);
    int b;
    b = 0;
    while (beats.size() < n && b < 400) begin
      @(posedge clk);
      b++;
    end
    #1;
    if (beats.size() < n) begin
      checks++;
      failures++;
      $display("FAIL %s wait: beats=%0d required %0d", name, beats.size(), n);
    end
  endtask

  task automatic check_beats(input string name);
    checks++;
    if (beats.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL %s count: got %0d required %0d", name, beats.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      checks++;
      if (beats[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s beat %0d: got last/par/data=%b/%b/%h required %b/%b/%h", name, i,
                 beats[i][5], beats[i][4], beats[i][3:0], exp_q[i][5], exp_q[i][4],
                 exp_q[i][3:0]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 6;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL reset m_valid: got %b required 0", m_valid); end
    if (m_data !== 4'h0) begin failures++; $display("FAIL reset m_data: got %h required 0", m_data); end
    if (m_parity !== 1'b0) begin failures++; $display("FAIL reset m_parity: got %b required 0", m_parity); end
    if (m_last !== 1'b0) begin failures++; $display("FAIL reset m_last: got %b required 0", m_last); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b required 0", busy); end
    if (s_ready !== 1'b1) begin failures++; $display("FAIL reset s_ready: got %b required 1", s_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_frame(input string name, input logic [3:0] last_val, input logic use_last);
    clear_all();
    m_ready = 1'b1;
    expect_frame(11, last_val);
    send_frame(11, last_val, use_last);
    wait_beats(15, name);
    // Let any spurious extra beat show up before checking the count
    repeat (4) @(posedge clk);
    #1;
    check_beats(name);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s busy: got %b required 0", name, busy); end
  endtask

  task automatic test_back_to_back();
    clear_all();
    m_ready = 1'b1;
    expect_frame(1, 4'h1);
    expect_frame(1, 4'h1);
    send_frame(1, 4'h1, 1'b1);
    send_frame(1, 4'h1, 1'b1);
    wait_beats(10, "b2b");
    check_beats("b2b");
    for (int i = 1; i < beat_cyc.size(); i++) begin
      checks++;
      if (beat_cyc[i] - beat_cyc[i-1] !== 1) begin
        failures++;
        $display("FAIL b2b gap beat %0d: got %0d cycles required 1", i, beat_cyc[i] - beat_cyc[i-1]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b busy: got %b required 0", busy); end
  endtask

  task automatic test_stall();
    clear_all();
    expect_frame(11, 4'h2);
    fork
      send_frame(11, 4'h2, 1'b0);
      begin
        logic       stalled;
        logic [5:0] held;
        stalled = 1'b0;
        held    = '0;
        for (int c = 0; c < 80; c++) begin
          @(posedge clk);
          #1;
          m_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (stalled) begin
            checks++;
            if ({m_last, m_parity, m_data} !== held) begin
              failures++;
              $display("FAIL stall hold: got %h required %h", {m_last, m_parity, m_data}, held);
            end
          end
          if (m_valid && !m_ready) begin
            checks++;
            if (s_ready !== 1'b0) begin
              failures++;
              $display("FAIL stall s_ready: got %b required 0", s_ready);
            end
            stalled = 1'b1;
            held    = {m_last, m_parity, m_data};
          end else begin
            stalled = 1'b0;
          end
        end
      end
    join
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_beats(15, "stall");
    check_beats("stall");
  endtask

  task automatic test_reset_mid();
    int np;
    int b;
    clear_all();
    m_ready = 1'b1;
    send_frame(11, 4'h2, 1'b0);
    np = 0;
    b  = 0;
    while (np < 2 && b < 50) begin
      @(posedge clk);
      #1;
      b++;
      if (m_valid && m_parity) np++;
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rstmid busy_before: got %b required 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    checks += 2;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL rstmid m_valid: got %b required 0", m_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rstmid busy: got %b required 0", busy); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_all();
    expect_frame(11, 4'h0);
    send_frame(11, 4'h0, 1'b0);
    wait_beats(15, "rstmid_zero");
    check_beats("rstmid_zero");
  endtask

  task automatic send_wsym(input logic [7:0] d, input logic last);
    int   budget;
    logic hs;
    w_s_valid = 1'b1;
    w_s_data  = d;
    w_s_last  = last;
    budget    = 0;
    hs        = 1'b0;
    while (!hs && budget < 200) begin
      @(negedge clk);
      hs = w_s_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    w_s_valid = 1'b0;
    w_s_last  = 1'b0;
    if (!hs) begin
      checks++;
      failures++;
      $display("FAIL wide send: s_ready never seen, got 0 required 1");
    end
  endtask

  task automatic test_wide_syndromes();
    logic [7:0] root;
    logic [7:0] syn;
    int         b;
    w_m_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wbeats.delete();
      for (int i = 0; i < 11; i++) send_wsym(8'($urandom_range(0, 255)), i == 10);
      b = 0;
      while (wbeats.size() < 27 && b < 200) begin
        @(posedge clk);
        b++;
      end
      #1;
      checks++;
      if (wbeats.size() !== 27) begin
        failures++;
        $display("FAIL wide frame %0d count: got %0d required 27", f, wbeats.size());
      end
      root = 8'h01;
      for (int j = 0; j < 16; j++) begin
        syn = 8'h00;
        for (int k = 0; k < wbeats.size(); k++) syn = gf8_mul(syn, root) ^ wbeats[k];
        checks++;
        if (syn !== 8'h00) begin
          failures++;
          $display("FAIL wide frame %0d syndrome %0d: got %h required 00", f, j, syn);
        end
        root = gf8_mul(root, 8'h02);
      end
    end
  endtask

  initial begin
    s_valid   = 1'b0;
    s_data    = 4'h0;
    s_last    = 1'b0;
    m_ready   = 1'b1;
    w_s_valid = 1'b0;
    w_s_data  = 8'h00;
    w_s_last  = 1'b0;
    w_m_ready = 1'b1;
    test_reset();
    test_frame("all_zero", 4'h0, 1'b0);
    test_frame("unit_last", 4'h1, 1'b1);
    test_frame("two", 4'h2, 1'b0);
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_wide_syndromes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
